// File: rtl/vec_operand_packer_pkg.sv
// Shared definitions for the vector adder datapath: the packer, the adder and the result consumer.
package vec_pkg;

  localparam int unsigned W_DEF   = 8;
  localparam int unsigned N_DEF   = 4;
  localparam int unsigned LAT_DEF = 2;

  typedef logic [W_DEF-1:0] elem_t;

  // Width of a lane count, sized so that the full-vector value N fits.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vec_operand_packer_if.sv
// Element stream in, packed vector plus result-valid sideband out.
interface vec_operand_packer_if
  import vec_pkg::*;
#(
  parameter int unsigned W = W_DEF,
  parameter int unsigned N = N_DEF
);

  localparam int unsigned CW = cnt_w(N);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          flush;
  logic [W-1:0]  a [N];
  logic [W-1:0]  b [N];
  logic          vec_valid;
  logic          y_valid;
  logic [CW-1:0] y_count;

  modport master (
    output in_valid, in_a, in_b, flush,
    input  in_ready, a, b, vec_valid, y_valid, y_count
  );

  modport slave (
    input  in_valid, in_a, in_b, flush,
    output in_ready, a, b, vec_valid, y_valid, y_count
  );

endinterface

// File: rtl/vec_operand_packer_valid_delay_pipe.sv
// Fixed-depth shift register carrying a valid bit and a payload; advances every cycle.
module valid_delay_pipe
  import vec_pkg::*;
#(
  parameter int unsigned DEPTH = LAT_DEF,
  parameter int unsigned PW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  input  logic [PW-1:0] data_i,
  output logic          valid_o,
  output logic [PW-1:0] data_o
);

  logic          vld_q [DEPTH];
  logic [PW-1:0] dat_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= valid_i;
      dat_q[0] <= data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/vec_operand_packer.sv
// Packs a serial (a,b) element stream into N-lane vectors for the adder and tags
// the adder's output cycles that carry real results.
module vec_operand_packer
  import vec_pkg::*;
#(
  parameter int unsigned W   = W_DEF,
  parameter int unsigned N   = N_DEF,
  parameter int unsigned LAT = LAT_DEF
) (
  input logic           clock,
  input logic           reset,
  vec_operand_packer_if.slave bus
);

  localparam int unsigned CW = cnt_w(N);
  typedef logic [CW-1:0] cnt_t;

  logic [W-1:0] fill_a_q [N];
  logic [W-1:0] fill_a_d [N];
  logic [W-1:0] fill_b_q [N];
  logic [W-1:0] fill_b_d [N];
  logic [W-1:0] out_a_q  [N];
  logic [W-1:0] out_a_d  [N];
  logic [W-1:0] out_b_q  [N];
  logic [W-1:0] out_b_d  [N];
  logic [W-1:0] stage_a  [N];
  logic [W-1:0] stage_b  [N];

  cnt_t cnt_q, cnt_d;
  cnt_t vec_cnt_q, vec_cnt_d;
  cnt_t k;
  logic ready_q;
  logic vec_valid_q, vec_valid_d;
  logic accept;
  logic emit;

  assign accept = bus.in_valid && ready_q;

  // The element accepted this cycle is merged first, so a flush coinciding with
  // the Nth accept sees k == N and produces a single full emission.
  always_comb begin
    k = cnt_q + cnt_t'(accept);
    for (int unsigned i = 0; i < N; i++) begin
      stage_a[i] = fill_a_q[i];
      stage_b[i] = fill_b_q[i];
      if (accept && (cnt_q == cnt_t'(i))) begin
        stage_a[i] = bus.in_a;
        stage_b[i] = bus.in_b;
      end
    end

    emit        = (k == cnt_t'(N)) || (bus.flush && (k != '0));
    fill_a_d    = stage_a;
    fill_b_d    = stage_b;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    cnt_d       = k;
    vec_valid_d = emit;
    vec_cnt_d   = '0;

    if (emit) begin
      cnt_d     = '0;
      vec_cnt_d = k;
      for (int unsigned i = 0; i < N; i++) begin
        fill_a_d[i] = '0;
        fill_b_d[i] = '0;
        out_a_d[i]  = (cnt_t'(i) < k) ? stage_a[i] : '0;
        out_b_d[i]  = (cnt_t'(i) < k) ? stage_b[i] : '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        fill_a_q[i] <= '0;
        fill_b_q[i] <= '0;
        out_a_q[i]  <= '0;
        out_b_q[i]  <= '0;
      end
      cnt_q       <= '0;
      vec_cnt_q   <= '0;
      vec_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      fill_a_q    <= fill_a_d;
      fill_b_q    <= fill_b_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      cnt_q       <= cnt_d;
      vec_cnt_q   <= vec_cnt_d;
      vec_valid_q <= vec_valid_d;
      ready_q     <= 1'b1;
    end
  end

  valid_delay_pipe #(
    .DEPTH (LAT),
    .PW    (CW)
  ) u_valid_delay_pipe (
    .clk_i   (clock),
    .rst_ni  (reset),
    .valid_i (vec_valid_q),
    .data_i  (vec_cnt_q),
    .valid_o (bus.y_valid),
    .data_o  (bus.y_count)
  );

  assign bus.in_ready  = ready_q;
  assign bus.a         = out_a_q;
  assign bus.b         = out_b_q;
  assign bus.vec_valid = vec_valid_q;

endmodule

// File: doc/vec_operand_packer.md
Name: vec_operand_packer

Overview:
- Upstream feeder for the registered N-lane vector adder stage.
- Accepts a serial stream of W-bit (a,b) element pairs over a valid/ready handshake and packs them into N-lane vectors, lane 0 first.
- Presents each completed vector on a held output bus that the adder samples every cycle.
- Emits a sideband valid/count pipeline aligned with the adder's 2-cycle result, so the downstream consumer knows which adder output cycles carry real results.

Parameters:
- W, 8, element width in bits.
- N, 4, lanes per vector (N >= 2).
- LAT, 2, adder latency in cycles from vector presentation to result.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  element pair valid.
- in_ready  out  1  packer can accept an element.
- in_a  in  W  operand A element.
- in_b  in  W  operand B element.
- flush  in  1  emit the current partial vector, zero-padded.
- a  out  [W-1:0] x N (unpacked)  packed operand A vector to the adder.
- b  out  [W-1:0] x N (unpacked)  packed operand B vector to the adder.
- vec_valid  out  1  one-cycle pulse: a/b hold a new vector this cycle.
- y_valid  out  1  pulse LAT cycles after vec_valid; adder output is a real result.
- y_count  out  $clog2(N+1)  number of real lanes in that result, aligned with y_valid.

Behaviour:
- Reset (reset low, async) forces: a, b, fill buffers and lane counter to 0; vec_valid, y_valid, y_count to 0; in_ready to 0; latency pipe cleared.
- in_ready is registered. It goes 1 on the first clock edge after reset deasserts and stays 1; the packer never back-pressures.
- Accept: in_valid && in_ready on a rising edge writes in_a/in_b into lane[cnt] of the fill buffer, then increments cnt.
- Full vector: when an accept occurs with cnt == N-1:
  - the fill buffer including this element is copied to a/b on that same edge;
  - vec_valid = 1 for the following cycle, with count = N;
  - cnt wraps to 0 and the fill buffer clears to 0.
- Flush: when flush is sampled high:
  - any element accepted in the same cycle is included first;
  - if the resulting count k is in 1..N, fill lanes 0..k-1 go to a/b, lanes k..N-1 are forced to 0, vec_valid pulses, count = k, cnt resets to 0;
  - if k == 0, flush is a no-op: no pulse, and a/b are unchanged.
- Flush coinciding with the Nth accept produces exactly one emission with count N, never a second empty one.
- Between emissions, a/b hold their last value. The adder keeps producing results, but y_valid stays 0 for those cycles.
- Latency pipe: a LAT-deep shift register of (valid, count).
  - Entry is (vec_valid, count). y_valid/y_count are taken from the last stage.
  - Net effect: y_valid rises exactly LAT cycles after the vec_valid cycle.
  - The pipe advances every cycle. Back-to-back vectors (one every N accepts, or a flush in every cycle) are supported with no bubbles.
- Reset asserted mid-vector discards partial lanes and all in-flight pipe entries; no y_valid is emitted for them.
- No arithmetic is performed here. The count width is $clog2(N+1) so the value N fits.

Decomposition:
- Shared package vec_pkg:
  - localparams W_DEF and N_DEF;
  - typedef elem_t = logic [W-1:0];
  - function cnt_w(N) = $clog2(N+1).
- The same package is to be imported by the adder and the result consumer.
- One natural sub-module: valid_delay_pipe. It is parameterised by depth LAT and payload width, uses async active-low reset, and carries (valid, count).
- The top level holds the lane counter, fill buffer, output registers and emit logic.

Test Plan:
- Reset, then 4 accepts with a = 1,2,3,4 and b = 10,20,30,40 on consecutive cycles:
  - a/b = {1,2,3,4}/{10,20,30,40} one cycle after the 4th accept, with vec_valid = 1 for exactly that cycle;
  - y_valid = 1 with y_count = 4 two cycles later;
  - the adder gives {11,22,33,44}.
- 2 accepts (a = 5,6; b = 7,8), then flush with in_valid low:
  - a = {5,6,0,0}, b = {7,8,0,0}, vec_valid pulses, y_count = 2 at y_valid.
- Flush with no pending elements:
  - no vec_valid, no y_valid, a/b unchanged.
- 3 accepts, then the 4th accept with flush high in the same cycle:
  - a single emission with count 4;
  - the next cycle shows cnt = 0 and no extra pulse.
- 8 back-to-back accepts:
  - vec_valid pulses twice, 4 cycles apart;
  - y_valid pulses twice with y_count = 4 each;
  - no dropped elements; in_ready stays 1.
- Reset pulled low asynchronously after 2 accepts and one cycle after a vec_valid:
  - all outputs go to 0 immediately, without waiting for a clock edge;
  - no y_valid appears after release;
  - the next 4 accepts form a fresh vector starting at lane 0.
